// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: repeat FSM states,
// default cycle counts and a counter-width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_STABLE_CYCLES = 65536;
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability counter, press/release
// strobes and, when HOLD_REPEAT_EN is defined, the hold/auto-repeat FSM.
//
// state  | meaning
// IDLE   | button released (or not yet accepted as pressed)
// HOLD   | press accepted, waiting HOLD_CYCLES for the first repeat
// REPEAT | emitting a repeat strobe every REPEAT_CYCLES
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic state_o,
    output logic pressed_o,
    output logic released_o,
    output logic repeat_o
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;
    logic          accept;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Stability counter: a level is accepted only after it differs from the
    // debounced state for STABLE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d      = cnt_q;
        state_d    = state_q;
        accept     = 1'b0;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            accept  = 1'b1;
            state_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        pressed_d  = accept & sync2_q;
        released_d = accept & ~sync2_q;
    end

    // Debounced state and registered strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            state_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign state_o    = state_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

`ifdef HOLD_REPEAT_EN
    localparam int RW = cnt_width(max2(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [RW-1:0] HOLD_TC = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);

    rep_state_e    fsm_q, fsm_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          repeat_q, repeat_d;

    // Repeat FSM next state; an accepted release always wins over a terminal count.
    always_comb begin
        fsm_d    = fsm_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (accept && sync2_q) begin
                    fsm_d  = HOLD;
                    rcnt_d = '0;
                end
            end
            HOLD: begin
                if (accept && !sync2_q) begin
                    fsm_d  = IDLE;
                    rcnt_d = '0;
                end else if (rcnt_q == HOLD_TC) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                    fsm_d    = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            REPEAT: begin
                if (accept && !sync2_q) begin
                    fsm_d  = IDLE;
                    rcnt_d = '0;
                end else if (rcnt_q == REP_TC) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: begin
                fsm_d  = IDLE;
                rcnt_d = '0;
            end
        endcase
    end

    // Repeat FSM state, counter and strobe registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q    <= IDLE;
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer top. Define HOLD_REPEAT_EN to build the
// hold/auto-repeat logic; otherwise btn_repeat is tied low with the same ports.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_pressed,
    output logic [N_CH-1:0] btn_released,
    output logic [N_CH-1:0] btn_repeat
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .btn_i     (btn_in[g]),
            .state_o   (btn_state[g]),
            .pressed_o (btn_pressed[g]),
            .released_o(btn_released[g]),
            .repeat_o  (btn_repeat[g])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: N_CH=2, STABLE=4, HOLD=10, REPEAT=5.
// Observed vector per cycle is {btn_state, btn_pressed, btn_released, btn_repeat}.
module tb_multi_debouncer;

`ifdef HOLD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in = 2'b11;
    logic [1:0] btn_state, btn_pressed, btn_released, btn_repeat;

    int total = 0;
    int bad   = 0;

    multi_debouncer #(
        .N_CH(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_state(btn_state), .btn_pressed(btn_pressed),
        .btn_released(btn_released), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {btn_state, btn_pressed, btn_released, btn_repeat};
    endfunction

    function automatic logic [1:0] rp(input bit hit, input logic [1:0] m);
        return (REP_EN && hit) ? m : 2'b00;
    endfunction

    task automatic test_reset();
        logic [7:0] e;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (obs() !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs(), 8'h00);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = {(i >= 6) ? 2'b11 : 2'b00, (i == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL reset_repress cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
        btn_in = 2'b00;
        for (int j = 1; j <= 8; j++) begin
            tick();
            e = {(j >= 6) ? 2'b00 : 2'b11, 2'b00, (j == 6) ? 2'b11 : 2'b00, 2'b00};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", j, obs(), e);
            end
        end
    endtask

    task automatic test_press_ch0();
        logic [7:0] e;
        btn_in = 2'b01;
        for (int i = 1; i <= 16; i++) begin
            tick();
            e = {(i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00,
                 rp(i == 16, 2'b01)};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL press_ch0 cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
        btn_in = 2'b00;
        for (int j = 1; j <= 8; j++) begin
            tick();
            e = {(j >= 6) ? 2'b00 : 2'b01, 2'b00, (j == 6) ? 2'b01 : 2'b00,
                 rp(j == 5, 2'b01)};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL release_ch0 cyc=%0d got=%b exp=%b", j, obs(), e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [13:0] pat;
        pat = 14'b00000001101110;
        for (int i = 0; i < 14; i++) begin
            btn_in = {1'b0, pat[13-i]};
            tick();
            total++;
            if (obs() !== 8'h00) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", i, obs(), 8'h00);
            end
        end
        btn_in = 2'b00;
    endtask

    task automatic test_repeat_ch1();
        logic [7:0] e;
        bit         hit;
        btn_in = 2'b10;
        for (int i = 1; i <= 48; i++) begin
            tick();
            hit = (i == 16) || (i == 21) || (i == 26) || (i == 31) || (i == 36);
            e = {(i >= 6 && i < 41) ? 2'b10 : 2'b00, (i == 6) ? 2'b10 : 2'b00,
                 (i == 41) ? 2'b10 : 2'b00, rp(hit, 2'b10)};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL repeat_ch1 cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            if (i == 35) btn_in = 2'b00;
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        logic [1:0] st;
        btn_in = 2'b10;
        for (int i = 1; i <= 20; i++) begin
            tick();
            st = (i < 6) ? 2'b00 : (i < 12) ? 2'b10 : 2'b01;
            e = {st, (i == 6) ? 2'b10 : (i == 12) ? 2'b01 : 2'b00,
                 (i == 12) ? 2'b10 : 2'b00, 2'b00};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            if (i == 6) btn_in = 2'b01;
        end
        btn_in = 2'b00;
        for (int j = 1; j <= 8; j++) begin
            tick();
            e = {(j >= 6) ? 2'b00 : 2'b01, 2'b00, (j == 6) ? 2'b01 : 2'b00,
                 rp(j == 2, 2'b01)};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL simul_release cyc=%0d got=%b exp=%b", j, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        btn_in = 2'b10;
        for (int i = 1; i <= 23; i++) begin
            tick();
            e = {(i >= 6) ? 2'b10 : 2'b00, (i == 6) ? 2'b10 : 2'b00, 2'b00,
                 rp((i == 16) || (i == 21), 2'b10)};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL pre_reset_mid cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            if (i == 18) btn_in = 2'b11;
        end
        rst = 1'b1;
        tick();
        total++;
        if (obs() !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=%b", obs(), 8'h00);
        end
        rst = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            e = {(j >= 6) ? 2'b11 : 2'b00, (j == 6) ? 2'b11 : 2'b00, 2'b00,
                 rp(j == 16, 2'b11)};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL post_reset_mid cyc=%0d got=%b exp=%b", j, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_ch0();
        test_bounce();
        test_repeat_ch1();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
